// File: rtl/nand3_stim_sequencer_if.sv
// Bundle between the characterisation harness, the sequencer and one NAND3 cell.
//   start/mode/num_vec : run request and its parameters (harness -> sequencer)
//   in1/in2/in3        : cell inputs driven by the sequencer
//   qn                 : cell output observed by the sequencer
//   busy/done          : run status (done is a one-cycle pulse)
//   tog_rise/tog_fall  : qn edge counts between consecutive samples
//   err_cnt/err_flag   : mismatch count against ~&vec and sticky mismatch flag
interface nand3_stim_sequencer_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned TOG_W = 24
);
  logic             start;
  logic [1:0]       mode;
  logic [CNT_W-1:0] num_vec;
  logic             in1;
  logic             in2;
  logic             in3;
  logic             qn;
  logic             busy;
  logic             done;
  logic [TOG_W-1:0] tog_rise;
  logic [TOG_W-1:0] tog_fall;
  logic [TOG_W-1:0] err_cnt;
  logic             err_flag;

  // Harness plus cell side.
  modport master (
    output start, mode, num_vec, qn,
    input  in1, in2, in3, busy, done, tog_rise, tog_fall, err_cnt, err_flag
  );

  // Sequencer side.
  modport slave (
    input  start, mode, num_vec, qn,
    output in1, in2, in3, busy, done, tog_rise, tog_fall, err_cnt, err_flag
  );
endinterface

// File: rtl/nand3_stim_sequencer.sv
// Stimulus sequencer for characterising a NAND3X1 cell.
// On start it walks a 3-bit vector sequence (binary, gray, LFSR or hold-toggle) onto the
// cell inputs, holds each vector SETTLE cycles, samples qn for one cycle, and keeps
// saturating counts of qn rising/falling edges and of samples that differ from ~&vec.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : nand3_stim_sequencer_if slave modport (see interface header)
module nand3_stim_sequencer #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned TOG_W  = 24,
  parameter int unsigned SETTLE = 2
) (
  input logic                   clk,
  input logic                   rst,
  nand3_stim_sequencer_if.slave bus
);

  localparam int unsigned      SCW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SCW-1:0]   SettleLoad = SCW'(SETTLE - 1);
  localparam logic [TOG_W-1:0] TogMax     = {TOG_W{1'b1}};

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StFinish} state_e;

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] num_vec_q, num_vec_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [SCW-1:0]   cnt_q, cnt_d;
  logic [2:0]       vec_q, vec_d;
  logic [2:0]       bin_q, bin_d;   // counter behind the binary and gray sequences
  logic             first_q, first_d;
  logic             prev_q, prev_d;
  logic [TOG_W-1:0] rise_q, rise_d;
  logic [TOG_W-1:0] fall_q, fall_d;
  logic [TOG_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_flag_q, err_flag_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2:0]       bin_nxt;

  function automatic logic [2:0] seed(input logic [1:0] m);
    case (m)
      2'b10:   return 3'b001;
      2'b11:   return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  // State register and all datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      mode_q     <= 2'b00;
      num_vec_q  <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      vec_q      <= 3'b000;
      bin_q      <= 3'b000;
      first_q    <= 1'b1;
      prev_q     <= 1'b0;
      rise_q     <= '0;
      fall_q     <= '0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      num_vec_q  <= num_vec_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      vec_q      <= vec_d;
      bin_q      <= bin_d;
      first_q    <= first_d;
      prev_q     <= prev_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    num_vec_d  = num_vec_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    vec_d      = vec_q;
    bin_d      = bin_q;
    first_d    = first_q;
    prev_d     = prev_q;
    rise_d     = rise_q;
    fall_d     = fall_q;
    err_cnt_d  = err_cnt_q;
    err_flag_d = err_flag_q;
    bin_nxt    = bin_q + 3'd1;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          mode_d     = bus.mode;
          num_vec_d  = bus.num_vec;
          rise_d     = '0;
          fall_d     = '0;
          err_cnt_d  = '0;
          err_flag_d = 1'b0;
          first_d    = 1'b1;
          if (bus.num_vec != '0) begin
            vec_d   = seed(bus.mode);
            bin_d   = 3'b000;
            cnt_d   = SettleLoad;
            idx_d   = '0;
            state_d = StSettle;
          end else begin
            state_d = StFinish;
          end
        end
      end
      StSettle: begin
        if (cnt_q == '0) state_d = StSample;
        else             cnt_d   = cnt_q - SCW'(1);
      end
      StSample: begin
        if (bus.qn != ~&vec_q) begin
          err_flag_d = 1'b1;
          if (err_cnt_q != TogMax) err_cnt_d = err_cnt_q + TOG_W'(1);
        end
        if (!first_q) begin
          if (bus.qn && !prev_q && rise_q != TogMax) rise_d = rise_q + TOG_W'(1);
          if (!bus.qn && prev_q && fall_q != TogMax) fall_d = fall_q + TOG_W'(1);
        end
        prev_d  = bus.qn;
        first_d = 1'b0;
        if (idx_q == num_vec_q - CNT_W'(1)) begin
          state_d = StFinish;
        end else begin
          case (mode_q)
            2'b00: begin
              bin_d = bin_nxt;
              vec_d = bin_nxt;
            end
            2'b01: begin
              bin_d = bin_nxt;
              vec_d = bin_nxt ^ (bin_nxt >> 1);
            end
            2'b10:   vec_d = {vec_q[1:0], vec_q[2] ^ vec_q[1]};
            default: vec_d = {~vec_q[2], vec_q[1:0]};  // 111 <-> 011
          endcase
          idx_d   = idx_q + CNT_W'(1);
          cnt_d   = SettleLoad;
          state_d = StSettle;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Status outputs are registered from the upcoming state so they align with it.
  always_comb begin
    busy_d = (state_d == StSettle) || (state_d == StSample);
    done_d = (state_d == StFinish);
  end

  assign bus.in1      = vec_q[2];
  assign bus.in2      = vec_q[1];
  assign bus.in3      = vec_q[0];
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.tog_rise = rise_q;
  assign bus.tog_fall = fall_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.err_flag = err_flag_q;

endmodule

// File: tb/tb_nand3_stim_sequencer.sv
// Scoreboard bench for nand3_stim_sequencer: the stimulus process computes each run's
// vector list and final counters from the sequence definitions and pushes them into
// queues; the monitor pops and compares as the DUT applies vectors and pulses done.
module tb_nand3_stim_sequencer;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned TOG_W = 24;
  localparam int          S     = 2;

  typedef struct {
    int done_cyc;
    int busy_cnt;
    int rise;
    int fall;
    int err;
    int flag;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  bit   stuck;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [2:0] vec_exp_q[$];
  res_t       res_q[$];

  nand3_stim_sequencer_if #(.CNT_W(CNT_W), .TOG_W(TOG_W)) bus ();

  nand3_stim_sequencer #(.CNT_W(CNT_W), .TOG_W(TOG_W), .SETTLE(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Cell model: a good NAND3, or output stuck at 1.
  assign bus.qn = stuck ? 1'b1 : ~(bus.in1 & bus.in2 & bus.in3);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Vector i of a sequence, from the sequence definitions.
  function automatic logic [2:0] ref_vec(input logic [1:0] m, input int i);
    int k;
    k = i % 8;
    case (m)
      2'd0: return 3'(k);
      2'd1: return 3'(k ^ (k >> 1));
      2'd2: begin
        case (i % 7)
          0:       return 3'd1;
          1:       return 3'd2;
          2:       return 3'd5;
          3:       return 3'd3;
          4:       return 3'd7;
          5:       return 3'd6;
          default: return 3'd4;
        endcase
      end
      default: return (i % 2 == 0) ? 3'b111 : 3'b011;
    endcase
  endfunction

  // Monitor: vector at the first busy cycle of each vector period, results at done.
  initial begin
    int   bc;
    res_t r;
    logic [2:0] v;
    bc = 0;
    forever begin
      @(negedge clk);
      if (bus.busy) begin
        bc++;
        if ((bc - 1) % (S + 1) == 0) begin
          if (vec_exp_q.size() == 0) begin
            check("vec_queue_has_entry", vec_exp_q.size(), 1);
          end else begin
            v = vec_exp_q.pop_front();
            check("vec", {bus.in1, bus.in2, bus.in3}, v);
          end
        end
      end else if (bus.done) begin
        if (res_q.size() == 0) begin
          check("res_queue_has_entry", res_q.size(), 1);
        end else begin
          r = res_q.pop_front();
          check("done_cycle", cyc, r.done_cyc);
          check("busy_cycles", bc, r.busy_cnt);
          check("tog_rise", bus.tog_rise, r.rise);
          check("tog_fall", bus.tog_fall, r.fall);
          check("err_cnt", bus.err_cnt, r.err);
          check("err_flag", bus.err_flag, r.flag);
        end
        bc = 0;
      end else begin
        bc = 0;
      end
    end
  end

  task automatic check_reset_state();
    check("rst_vec", {bus.in1, bus.in2, bus.in3}, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_tog_rise", bus.tog_rise, 0);
    check("rst_tog_fall", bus.tog_fall, 0);
    check("rst_err_cnt", bus.err_cnt, 0);
    check("rst_err_flag", bus.err_flag, 0);
  endtask

  // Called and returns 1 time unit after a rising edge.
  task automatic run(input logic [1:0] m, input int nv, input bit stk, input bit poke);
    int   rise, fall, err;
    logic prev, q;
    logic [2:0] v;
    res_t r;
    bit   seen;
    rise = 0; fall = 0; err = 0; prev = 1'b0;
    stuck = stk;
    for (int i = 0; i < nv; i++) begin
      v = ref_vec(m, i);
      vec_exp_q.push_back(v);
      q = stk ? 1'b1 : ~&v;
      if (q != ~&v) err++;
      if (i > 0) begin
        if (q && !prev) rise++;
        if (!q && prev) fall++;
      end
      prev = q;
    end
    r.done_cyc = cyc + (S + 1) * nv + 1;
    r.busy_cnt = (S + 1) * nv;
    r.rise     = rise;
    r.fall     = fall;
    r.err      = err;
    r.flag     = (err > 0) ? 1 : 0;
    res_q.push_back(r);

    bus.start   = 1'b1;
    bus.mode    = m;
    bus.num_vec = CNT_W'(nv);
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.mode    = 2'($urandom);
    bus.num_vec = CNT_W'($urandom);
    if (poke && nv > 0) begin
      // A start while busy must be ignored.
      @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
    end
    seen = 1'b0;
    for (int k = 0; k < (S + 1) * nv + 20 && !seen; k++) begin
      @(negedge clk);
      seen = bus.done;
    end
    if (!seen) check("done_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // Reset in cycle 10 of a binary 8-vector run: no done, outputs back to reset state.
  task automatic run_abort();
    stuck = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (1 + i * (S + 1) <= 10) vec_exp_q.push_back(ref_vec(2'd0, i));
    end
    bus.start   = 1'b1;
    bus.mode    = 2'd0;
    bus.num_vec = CNT_W'(8);
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    stuck       = 1'b0;
    bus.start   = 1'b0;
    bus.mode    = 2'd0;
    bus.num_vec = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state();
    @(posedge clk);
    #1;

    run(2'd0, 8, 1'b0, 1'b0);
    run(2'd1, 8, 1'b0, 1'b0);
    run(2'd2, 14, 1'b0, 1'b0);
    run(2'd3, 10, 1'b0, 1'b1);
    run(2'd0, 8, 1'b1, 1'b0);
    run(2'd0, 8, 1'b0, 1'b0);
    run_abort();
    run(2'd2, 0, 1'b0, 1'b0);
    run(2'd1, 1, 1'b0, 1'b0);
    for (int n = 0; n < 12; n++) begin
      run(2'($urandom), int'($urandom_range(1, 20)), 1'($urandom), 1'($urandom));
    end

    repeat (5) @(posedge clk);
    check("vec_queue_drained", vec_exp_q.size(), 0);
    check("res_queue_drained", res_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/nand3_stim_sequencer.md
Name: nand3_stim_sequencer

Overview:
- Stimulus controller for power and function characterisation of a NAND3X1 cell instance: inputs IN1/IN2/IN3, output QN.
- On START it walks a programmable 3-bit vector sequence onto the cell inputs, waits a settle window per vector, then samples QN.
- It counts QN rising and falling transitions and checks each sample against the expected NAND3 value.
- It sits between the test harness (START/DONE handshake) and one cell under test.

Parameters:
- CNT_W, 16: width of the vector-count input NUM_VEC.
- TOG_W, 24: width of the toggle and error counters. All counters saturate at 2^TOG_W-1.
- SETTLE, 2: clock cycles each vector is held before QN is sampled. Legal range ≥1.

Ports:
- CLK, input, 1: rising-edge clock.
- RST, input, 1: synchronous, active-high reset.
- START, input, 1: run request. Sampled only in IDLE.
- MODE, input, 2: sequence select, latched at START. 00 binary, 01 gray, 10 LFSR, 11 hold-toggle.
- NUM_VEC, input, CNT_W: number of vectors to apply, latched at START.
- IN1, output, 1: cell input, vec[2].
- IN2, output, 1: cell input, vec[1].
- IN3, output, 1: cell input, vec[0].
- QN, input, 1: cell output, sampled in SAMPLE.
- BUSY, output, 1: high in SETTLE and SAMPLE.
- DONE, output, 1: one-cycle pulse in FINISH.
- TOG_RISE, output, TOG_W: count of QN 0→1 between consecutive samples.
- TOG_FALL, output, TOG_W: count of QN 1→0 between consecutive samples.
- ERR_CNT, output, TOG_W: count of samples where QN ≠ ~&vec.
- ERR_FLAG, output, 1: sticky; set on the first mismatch.

Behaviour:
- Reset: all outputs are registered. On RST, at the next edge: vec=000, BUSY=0, DONE=0, all counters 0, ERR_FLAG=0, state IDLE, first-sample flag set. RST mid-run aborts the run immediately. No DONE is issued.
- States: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE:
  - START=1 and NUM_VEC≠0: latch MODE and NUM_VEC, clear TOG_RISE/TOG_FALL/ERR_CNT/ERR_FLAG, load the seed vector, load the settle counter, load the vector index to 0, go to SETTLE.
  - START=1 and NUM_VEC=0: clear the counters and go to FINISH with no vector applied.
  - START=0: stay in IDLE; outputs hold their last values.
- Seeds: binary 000; gray 000; LFSR 001; hold-toggle 111.
- SETTLE: lasts exactly SETTLE cycles, then go to SAMPLE.
- SAMPLE: one cycle. QN is sampled at the end of this cycle.
  - Mismatch (QN ≠ ~&vec): ERR_CNT+1 (saturating) and ERR_FLAG←1.
  - Edge counting: if not the first sample, compare QN with the previous sample and increment TOG_RISE or TOG_FALL (saturating). The first sample never counts an edge.
  - If index = NUM_VEC-1, go to FINISH; vec holds.
  - Otherwise advance vec, increment the index, go to SETTLE.
- Advance rules:
  - Binary: b←b+1 mod 8, vec=b.
  - Gray: b←b+1 mod 8, vec=b^(b>>1).
  - LFSR: vec←{vec[1:0], vec[2]^vec[1]}. Period 7: 001,010,101,011,111,110,100. The all-zero vector is never produced.
  - Hold-toggle: vec alternates 111↔011.
- FINISH: DONE=1 and BUSY=0 for one cycle, then IDLE. vec holds the last applied vector. Counters hold until the next accepted START.
- Timing: START accepted at cycle 0 puts the first vector on IN1..3 at cycle 1. Vector period is SETTLE+1 cycles. BUSY is high for cycles 1..(SETTLE+1)·NUM_VEC. DONE is high in cycle (SETTLE+1)·NUM_VEC+1.
- START while BUSY or in FINISH is ignored. Back-to-back: START in the cycle after DONE is accepted.
- The index counter is CNT_W bits wide, so NUM_VEC=2^CNT_W-1 runs to completion without wrap.

Test Plan:
- SETTLE=2, MODE=00, NUM_VEC=8, good cell → IN walks 000..111; BUSY cycles 1–24; DONE cycle 25; TOG_RISE=0, TOG_FALL=1, ERR_CNT=0, ERR_FLAG=0.
- MODE=01, NUM_VEC=8 → vec 000,001,011,010,110,111,101,100; TOG_RISE=1, TOG_FALL=1, ERR_CNT=0.
- MODE=10, NUM_VEC=14 → LFSR sequence run twice, never 000; TOG_RISE=2, TOG_FALL=2; DONE cycle 43.
- MODE=11, NUM_VEC=10 → QN samples 0,1,0,1…; TOG_RISE=5, TOG_FALL=4, ERR_CNT=0.
- QN tied to 1, MODE=00, NUM_VEC=8 → ERR_CNT=1 (at vec 111), ERR_FLAG=1, TOG_RISE=TOG_FALL=0. A second START with a good cell clears ERR_FLAG.
- RST at cycle 10 of a NUM_VEC=8 run → next cycle IN=000, BUSY=0, counters 0, no DONE. START with NUM_VEC=0 → DONE at cycle 1, BUSY never high. START during BUSY → ignored.
